hwpe_stream_realign_addrgen: RTL and testbench

Line-based address generator for misaligned HWPE-Stream loads. It walks a 2D region (lines of arbitrary byte length and start alignment) and issues word-aligned TCDM load addresses, one per cycle. With each address it produces the per-word strobe and the `ctrl_realign_t` control bundle (`first`, `last`, `last_packet`, `realign`, `strb_valid`, `line_length`). That bundle drives the downstream source realigner in its decoupled configuration. It sits between the streamer controller and the TCDM load port.

---
 rtl/hwpe_stream_package.sv | 48 ++++
 rtl/hwpe_stream_realign_addrgen.sv | 185 ++++++++++++++++++
 tb/tb_hwpe_stream_realign_addrgen.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_package.sv
// HWPE-Stream shared types: realigner control bundle,
// addrgen job config, FSM states and strobe-mask helper.
package hwpe_stream_package;

  localparam int unsigned MAX_B = 128;

  typedef struct packed {
    logic        enable;
    logic        strb_valid;
    logic        realign;
    logic        first;
    logic        last;
    logic        last_packet;
    logic [15:0] line_length;
  } ctrl_realign_t;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [15:0] line_bytes;
    logic [31:0] line_stride;
    logic [15:0] n_lines;
  } ctrl_addrgen_realign_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } addrgen_state_e;

  // first word drops bytes below off, last word keeps bytes below endb
  function automatic logic [MAX_B-1:0] realign_strb(
    input int unsigned b,
    input int unsigned off,
    input int unsigned endb,
    input logic        first,
    input logic        last
  );
    logic [MAX_B-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_B; i++) begin
      m[i] = (i < b)
           && (!first || i >= off)
           && (!last || endb == 0 || i < endb);
    end
    return m;
  endfunction

endpackage

// File: rtl/hwpe_stream_realign_addrgen.sv
// Line-based word-aligned load address generator
// feeding a decoupled source realigner.
module hwpe_stream_realign_addrgen
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [15:0]             line_bytes_i,
  input  logic [ADDR_WIDTH-1:0]   line_stride_i,
  input  logic [15:0]             n_lines_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    addr_valid_o,
  input  logic                    addr_ready_i,
  output logic [DATA_WIDTH/8-1:0] strb_o,
  output ctrl_realign_t           ctrl_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned B = DATA_WIDTH / 8;
  localparam int unsigned O = $clog2(B);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ~ADDR_WIDTH'(B - 1);

  addrgen_state_e state_q, state_d;

  logic [O-1:0]          off_q, off_d;
  logic [O-1:0]          end_q, end_d;
  logic                  realign_q, realign_d;
  logic [15:0]           len_q, len_d;
  logic [16:0]           wlast_q, wlast_d;
  logic [15:0]           nlast_q, nlast_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] lbase_q, lbase_d;
  logic [16:0]           word_q, word_d;
  logic [15:0]           line_q, line_d;

  ctrl_addrgen_realign_t cfg;
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic                  run, en, hs;
  logic                  is_first, is_last;
  logic                  is_lline;

  assign cfg = '{
    base_addr:   32'(base_addr_i),
    line_bytes:  line_bytes_i,
    line_stride: 32'(line_stride_i),
    n_lines:     n_lines_i
  };
  assign cfg_base = ADDR_WIDTH'(cfg.base_addr);

  assign run = (state_q == RUN);
  assign en  = (state_q != IDLE);
  assign hs  = run & addr_ready_i;

  assign is_first = (word_q == '0);
  assign is_last  = (word_q == wlast_q);
  assign is_lline = (line_q == nlast_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      off_q     <= '0;
      end_q     <= '0;
      realign_q <= 1'b0;
      len_q     <= '0;
      wlast_q   <= '0;
      nlast_q   <= '0;
      stride_q  <= '0;
      lbase_q   <= '0;
      word_q    <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      end_q     <= end_d;
      realign_q <= realign_d;
      len_q     <= len_d;
      wlast_q   <= wlast_d;
      nlast_q   <= nlast_d;
      stride_q  <= stride_d;
      lbase_q   <= lbase_d;
      word_q    <= word_d;
      line_q    <= line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    end_d     = end_q;
    realign_d = realign_q;
    len_d     = len_q;
    wlast_d   = wlast_q;
    nlast_d   = nlast_q;
    stride_d  = stride_q;
    lbase_d   = lbase_q;
    word_d    = word_q;
    line_d    = line_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          off_d     = cfg_base[O-1:0];
          realign_d = (cfg_base[O-1:0] != '0);
          end_d     = cfg_base[O-1:0]
                    + cfg.line_bytes[O-1:0];
          len_d     = 16'(({1'b0, cfg.line_bytes}
                    + 17'(B - 1)) >> O);
          wlast_d   = 17'(len_d) + 17'(realign_d)
                    - 17'd1;
          nlast_d   = cfg.n_lines - 16'd1;
          stride_d  = ADDR_WIDTH'(cfg.line_stride);
          lbase_d   = cfg_base & AMASK;
          word_d    = '0;
          line_d    = '0;
          if (cfg.line_bytes == '0 ||
              cfg.n_lines == '0)
            state_d = DONE;
          else
            state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (is_last) begin
            word_d = '0;
            if (is_lline) begin
              line_d  = '0;
              state_d = DONE;
            end else begin
              line_d  = line_q + 16'd1;
              lbase_d = lbase_q + (stride_q & AMASK);
            end
          end else begin
            word_d = word_q + 17'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // soft clear aborts any job without a done pulse
    if (clear_i) begin
      state_d = IDLE;
      word_d  = '0;
      line_d  = '0;
      lbase_d = '0;
    end
  end

  assign addr_valid_o = run;
  assign busy_o       = en;
  assign done_o       = (state_q == DONE);

  assign addr_o = run
    ? lbase_q + (ADDR_WIDTH'(word_q) << O)
    : '0;

  assign strb_o = run
    ? B'(realign_strb(B, 32'(off_q), 32'(end_q),
                      is_first, is_last))
    : '0;

  always_comb begin
    ctrl_o = '0;
    if (en) begin
      ctrl_o.enable      = 1'b1;
      ctrl_o.realign     = realign_q;
      ctrl_o.line_length = len_q;
    end
    if (run) begin
      ctrl_o.first       = is_first;
      ctrl_o.last        = is_last;
      ctrl_o.last_packet = is_last & is_lline;
      ctrl_o.strb_valid  = hs;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_realign_addrgen.sv
// Scoreboard bench for hwpe_stream_realign_addrgen:
// directed jobs queue expected requests, a monitor checks them.
module tb_hwpe_stream_realign_addrgen;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] line_bytes_i = '0;
  logic [31:0] line_stride_i = '0;
  logic [15:0] n_lines_i = '0;
  logic        addr_ready_i = 1'b1;
  logic [31:0] addr_o;
  logic        addr_valid_o;
  logic [3:0]  strb_o;
  hwpe_stream_package::ctrl_realign_t ctrl_o;
  logic        busy_o;
  logic        done_o;

  hwpe_stream_realign_addrgen #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .line_bytes_i (line_bytes_i),
    .line_stride_i(line_stride_i),
    .n_lines_i    (n_lines_i),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid_o),
    .addr_ready_i (addr_ready_i),
    .strb_o       (strb_o),
    .ctrl_o       (ctrl_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [2:0]  flg;
    logic        ra;
    logic [15:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   hs_cyc = -10;
  bit   sb_on = 1'b1;
  bit   bp_mode = 1'b0;
  int   bp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, req);
  endtask

  task automatic push(input logic [31:0] a,
                      input logic [3:0] s,
                      input logic [2:0] flg,
                      input logic ra,
                      input logic [15:0] len);
    exp_t e;
    e.addr = a; e.strb = s; e.flg = flg;
    e.ra = ra; e.len = len;
    exp_q.push_back(e);
  endtask

  // ready driver: plain or stall-then-random
  initial forever begin
    @(posedge clk); #1;
    if (!bp_mode) addr_ready_i = 1'b1;
    else begin
      if (addr_valid_o) bp_cnt++;
      if (bp_cnt < 2) addr_ready_i = 1'b1;
      else if (bp_cnt <= 4) addr_ready_i = 1'b0;
      else addr_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // monitor
  initial begin
    logic        pstall;
    logic [31:0] pa;
    logic [3:0]  ps;
    logic [20:0] pc;
    exp_t        e;
    pstall = 1'b0; pa = '0; ps = '0; pc = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          chk("stall_valid", 32'(addr_valid_o), 1);
          chk("stall_addr", addr_o, pa);
          chk("stall_strb", 32'(strb_o), 32'(ps));
          chk("stall_ctrl",
              32'({ctrl_o.first, ctrl_o.last,
                   ctrl_o.last_packet, ctrl_o.realign,
                   ctrl_o.line_length}), 32'(pc));
        end
        pstall = addr_valid_o & ~addr_ready_i;
        pa = addr_o; ps = strb_o;
        pc = {ctrl_o.first, ctrl_o.last,
              ctrl_o.last_packet, ctrl_o.realign,
              ctrl_o.line_length};
        if (addr_valid_o && !addr_ready_i)
          chk("strbv_nohs", 32'(ctrl_o.strb_valid), 0);
        if (sb_on && addr_valid_o && addr_ready_i) begin
          hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_req", addr_o, 32'hdead);
          end else begin
            e = exp_q.pop_front();
            chk("addr", addr_o, e.addr);
            chk("strb", 32'(strb_o), 32'(e.strb));
            chk("flags", 32'({ctrl_o.first, ctrl_o.last,
                              ctrl_o.last_packet}),
                32'(e.flg));
            chk("realign", 32'(ctrl_o.realign), 32'(e.ra));
            chk("line_len", 32'(ctrl_o.line_length),
                32'(e.len));
            chk("strbv_hs", 32'(ctrl_o.strb_valid), 1);
          end
        end
      end
    end
  end

  task automatic drive_cfg(input logic [31:0] b,
                           input logic [15:0] nb,
                           input logic [31:0] st,
                           input logic [15:0] nl);
    base_addr_i = b; line_bytes_i = nb;
    line_stride_i = st; n_lines_i = nl;
  endtask

  task automatic run_job(input logic [31:0] b,
                         input logic [15:0] nb,
                         input logic [31:0] st,
                         input logic [15:0] nl,
                         input bit glitch,
                         input string nm);
    bit got;
    @(posedge clk); #1;
    drive_cfg(b, nb, st, nl);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (glitch) begin
      drive_cfg(32'h5000, 16'd3, 32'h40, 16'd7);
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_o) begin got = 1'b1; break; end
    end
    chk({nm, "_done_seen"}, 32'(got), 1);
    if (got) begin
      chk({nm, "_done_lat"}, cyc, hs_cyc + 1);
      chk({nm, "_busy_done"}, 32'(busy_o), 1);
      chk({nm, "_pending"}, exp_q.size(), 0);
    end
    @(negedge clk);
    chk({nm, "_idle"},
        32'({busy_o, done_o, addr_valid_o}), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_addr"}, addr_o, 0);
    chk({nm, "_strb"}, 32'(strb_o), 0);
    chk({nm, "_ctrl"}, 32'(ctrl_o), 0);
    chk({nm, "_flags"},
        32'({addr_valid_o, busy_o, done_o}), 0);
  endtask

  task automatic push_job1();
    push(32'h1000, 4'b1100, 3'b100, 1'b1, 16'd3);
    push(32'h1004, 4'b1111, 3'b000, 1'b1, 16'd3);
    push(32'h1008, 4'b1111, 3'b000, 1'b1, 16'd3);
    push(32'h100C, 4'b1111, 3'b010, 1'b1, 16'd3);
    push(32'h1100, 4'b1100, 3'b100, 1'b1, 16'd3);
    push(32'h1104, 4'b1111, 3'b000, 1'b1, 16'd3);
    push(32'h1108, 4'b1111, 3'b000, 1'b1, 16'd3);
    push(32'h110C, 4'b1111, 3'b011, 1'b1, 16'd3);
  endtask

  task automatic push_job2();
    push(32'h2000, 4'b1111, 3'b100, 1'b0, 16'd2);
    push(32'h2004, 4'b0011, 3'b011, 1'b0, 16'd2);
  endtask

  initial begin
    #1;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    chk_zero("idle");

    push_job1();
    run_job(32'h1002, 16'd10, 32'h100, 16'd2, 0, "mis2");

    push_job2();
    run_job(32'h2000, 16'd6, 32'h0, 16'd1, 0, "alig");

    push(32'h3000, 4'b1110, 3'b100, 1'b1, 16'd1);
    push(32'h3004, 4'b0111, 3'b011, 1'b1, 16'd1);
    run_job(32'h3001, 16'd2, 32'h0, 16'd1, 0, "mis1");

    push(32'h3000, 4'b0011, 3'b111, 1'b0, 16'd1);
    run_job(32'h3000, 16'd2, 32'h0, 16'd1, 0, "w1");

    push(32'hFFFFFFFC, 4'b1111, 3'b110, 1'b0, 16'd1);
    push(32'h00000000, 4'b1111, 3'b111, 1'b0, 16'd1);
    run_job(32'hFFFFFFFC, 16'd4, 32'h4, 16'd2, 0, "wrap");

    bp_cnt = 0; bp_mode = 1'b1;
    push_job1();
    run_job(32'h1002, 16'd10, 32'h100, 16'd2, 0, "bp");
    bp_mode = 1'b0;

    push_job2();
    run_job(32'h2000, 16'd6, 32'h0, 16'd1, 1, "glitch");

    // empty jobs
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive_cfg(32'h4000, 16'd8, 32'h10, 16'd0);
      else        drive_cfg(32'h4000, 16'd0, 32'h10, 16'd3);
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("empty_done", 32'(done_o), 1);
      chk("empty_valid", 32'(addr_valid_o), 0);
      @(posedge clk); #1;
      chk("empty_after",
          32'({done_o, addr_valid_o, busy_o}), 0);
    end

    // soft clear mid-job
    sb_on = 1'b0;
    @(posedge clk); #1;
    drive_cfg(32'h1002, 16'd10, 32'h100, 16'd2);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    chk_zero("clear");
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done_o) seen = 1'b1;
      end
      chk("clear_no_done", 32'(seen), 0);
    end

    // async reset mid-job
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b0;
    #1 chk_zero("arst");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    sb_on = 1'b1;

    push_job2();
    run_job(32'h2000, 16'd6, 32'h0, 16'd1, 0, "post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
